rca_config_bank: RTL and testbench

- Next-generation RCA operand-routing configuration store, sitting between the RCA config CSR path and the RCA issue/decode logic.
- Each RCA holds two copies of its source/destination register-address table: a shadow copy, written by software, and an active copy, read by issue.
- A per-RCA commit handshake copies shadow to active only once that RCA has no operations in flight. Reconfiguration therefore never corrupts an executing RCA.
- Read port width, write port width, RCA count and address width are all parametrised.

---
 rtl/rca_config_bank_pkg.sv | 38 +++
 rtl/rca_config_bank_commit_fsm.sv | 46 ++++
 rtl/rca_config_bank.sv | 179 +++++++++++++++++
 tb/tb_rca_config_bank.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rca_config_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rca_config_bank_pkg
// Description : Shared types and constants for the RCA operand-routing
//               configuration bank (RCA ids, commit states, table entry).
// Revision    : 1.0 - initial release
// ============================================================================
package rca_config_bank_pkg;

  localparam int c_NUM_RCAS        = 3;
  localparam int c_NUM_READ_PORTS  = 5;
  localparam int c_NUM_WRITE_PORTS = 2;
  localparam int c_ADDR_W          = 5;

  // Width of a select able to index the larger of the two port tables.
  function automatic int sel_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int PORT_SEL_W = sel_width(c_NUM_READ_PORTS, c_NUM_WRITE_PORTS);
  localparam int RCA_ID_W   = (c_NUM_RCAS > 1) ? $clog2(c_NUM_RCAS) : 1;

  typedef logic [RCA_ID_W-1:0] rca_id_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } rca_cfg_state_t;

  typedef struct packed {
    logic [c_NUM_READ_PORTS-1:0][c_ADDR_W-1:0]  src;
    logic [c_NUM_WRITE_PORTS-1:0][c_ADDR_W-1:0] dest;
  } rca_cfg_entry_t;

endpackage : rca_config_bank_pkg
`default_nettype wire

// File: rtl/rca_config_bank_commit_fsm.sv
`default_nettype none
// ============================================================================
// Module      : rca_commit_fsm
// Description : Per-RCA commit handshake. An accepted commit parks the FSM in
//               PENDING until the RCA reports no work in flight; on that edge
//               copy_en tells the bank to move shadow into active.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_commit_fsm
  import rca_config_bank_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  input  logic busy,
  output logic pending,
  output logic copy_en
);

  localparam logic [0:0] c_ST_IDLE    = 1'(IDLE);
  localparam logic [0:0] c_ST_PENDING = 1'(PENDING);

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;

  // Next-state: wait in PENDING until the RCA drains.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:    if (accept) w_state_nxt = c_ST_PENDING;
      c_ST_PENDING: if (!busy)  w_state_nxt = c_ST_IDLE;
      default:      w_state_nxt = c_ST_IDLE;
    endcase
  end

  // State register; reset abandons any commit in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign pending = (r_state == c_ST_PENDING);
  assign copy_en = pending && !busy;

endmodule : rca_commit_fsm
`default_nettype wire

// File: rtl/rca_config_bank.sv
`default_nettype none
// ============================================================================
// Module      : rca_config_bank
// Description : Double-buffered RCA source/destination register-address
//               tables. Software writes the shadow copy; a per-RCA commit
//               copies shadow to active once the RCA is idle; issue reads
//               the active copy through a registered port.
//               Optional macro RCA_CFG_ERR_EN adds a sticky cfg_err flag for
//               out-of-range writes, commits and reads (cleared by
//               cfg_err_clr).
// Revision    : 1.0 - initial release
// ============================================================================
module rca_config_bank
  import rca_config_bank_pkg::*;
#(
  parameter int NUM_RCAS        = c_NUM_RCAS,
  parameter int NUM_READ_PORTS  = c_NUM_READ_PORTS,
  parameter int NUM_WRITE_PORTS = c_NUM_WRITE_PORTS,
  parameter int ADDR_W          = c_ADDR_W,
  parameter int PORT_SEL_W      = sel_width(NUM_READ_PORTS, NUM_WRITE_PORTS),
  parameter int RCA_SEL_W       = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      cfg_wr_valid,
  output logic                                      cfg_wr_ready,
  input  logic [RCA_SEL_W-1:0]                      cfg_rca_sel,
  input  logic                                      cfg_is_dest,
  input  logic [PORT_SEL_W-1:0]                     cfg_port_sel,
  input  logic [ADDR_W-1:0]                         cfg_reg_addr,
  input  logic                                      commit_valid,
  output logic                                      commit_ready,
  input  logic [RCA_SEL_W-1:0]                      commit_rca_sel,
  input  logic [NUM_RCAS-1:0]                       rca_busy,
  input  logic                                      rd_en,
  input  logic [RCA_SEL_W-1:0]                      rd_rca_sel,
  output logic [NUM_READ_PORTS-1:0][ADDR_W-1:0]     rd_src_addrs,
  output logic [NUM_WRITE_PORTS-1:0][ADDR_W-1:0]    rd_dest_addrs,
  output logic                                      rd_cfg_valid,
  output logic [NUM_RCAS-1:0]                       commit_pending
`ifdef RCA_CFG_ERR_EN
  ,
  input  logic                                      cfg_err_clr,
  output logic                                      cfg_err
`endif
);

  logic [NUM_READ_PORTS-1:0][ADDR_W-1:0]  r_shadow_src  [NUM_RCAS];
  logic [NUM_WRITE_PORTS-1:0][ADDR_W-1:0] r_shadow_dest [NUM_RCAS];
  logic [NUM_READ_PORTS-1:0][ADDR_W-1:0]  r_active_src  [NUM_RCAS];
  logic [NUM_WRITE_PORTS-1:0][ADDR_W-1:0] r_active_dest [NUM_RCAS];
  logic [NUM_RCAS-1:0]                    r_active_valid;

  logic [NUM_READ_PORTS-1:0][ADDR_W-1:0]  r_rd_src;
  logic [NUM_WRITE_PORTS-1:0][ADDR_W-1:0] r_rd_dest;
  logic                                   r_rd_valid;

  logic [NUM_RCAS-1:0] w_pending;
  logic [NUM_RCAS-1:0] w_copy_en;
  logic [NUM_RCAS-1:0] w_accept;
  logic                w_wr_fire;

  // Handshake readiness; out-of-range selects are always ready and dropped.
  always_comb begin
    cfg_wr_ready = 1'b1;
    commit_ready = 1'b1;
    for (int i = 0; i < NUM_RCAS; i++) begin
      if (cfg_rca_sel == RCA_SEL_W'(i))    cfg_wr_ready = ~w_pending[i];
      if (commit_rca_sel == RCA_SEL_W'(i)) commit_ready = ~w_pending[i];
    end
  end

  assign w_wr_fire = cfg_wr_valid && cfg_wr_ready;

  generate
    for (genvar i = 0; i < NUM_RCAS; i++) begin : g_rca
      assign w_accept[i] = commit_valid && commit_ready &&
                           (commit_rca_sel == RCA_SEL_W'(i));

      rca_commit_fsm u_commit_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .accept  (w_accept[i]),
        .busy    (rca_busy[i]),
        .pending (w_pending[i]),
        .copy_en (w_copy_en[i])
      );
    end
  endgenerate

  assign commit_pending = w_pending;

  // Shadow tables: software writes; entries past the table length match no slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RCAS; i++) begin
        r_shadow_src[i]  <= '0;
        r_shadow_dest[i] <= '0;
      end
    end else if (w_wr_fire) begin
      for (int i = 0; i < NUM_RCAS; i++) begin
        if (cfg_rca_sel == RCA_SEL_W'(i)) begin
          for (int p = 0; p < NUM_READ_PORTS; p++)
            if (!cfg_is_dest && cfg_port_sel == PORT_SEL_W'(p))
              r_shadow_src[i][p] <= cfg_reg_addr;
          for (int p = 0; p < NUM_WRITE_PORTS; p++)
            if (cfg_is_dest && cfg_port_sel == PORT_SEL_W'(p))
              r_shadow_dest[i][p] <= cfg_reg_addr;
        end
      end
    end
  end

  // Active tables: whole-table copy from shadow when the commit completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_valid <= '0;
      for (int i = 0; i < NUM_RCAS; i++) begin
        r_active_src[i]  <= '0;
        r_active_dest[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RCAS; i++) begin
        if (w_copy_en[i]) begin
          r_active_src[i]   <= r_shadow_src[i];
          r_active_dest[i]  <= r_shadow_dest[i];
          r_active_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Registered read of the active table; a concurrent copy is seen next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_src   <= '0;
      r_rd_dest  <= '0;
      r_rd_valid <= 1'b0;
    end else if (rd_en) begin
      r_rd_src   <= '0;
      r_rd_dest  <= '0;
      r_rd_valid <= 1'b0;
      for (int i = 0; i < NUM_RCAS; i++) begin
        if (rd_rca_sel == RCA_SEL_W'(i)) begin
          r_rd_src   <= r_active_src[i];
          r_rd_dest  <= r_active_dest[i];
          r_rd_valid <= r_active_valid[i];
        end
      end
    end
  end

  assign rd_src_addrs  = r_rd_src;
  assign rd_dest_addrs = r_rd_dest;
  assign rd_cfg_valid  = r_rd_valid;

`ifdef RCA_CFG_ERR_EN
  logic w_err_set;
  logic r_cfg_err;

  assign w_err_set =
      (w_wr_fire && ((int'(cfg_rca_sel) >= NUM_RCAS) ||
                     (!cfg_is_dest && int'(cfg_port_sel) >= NUM_READ_PORTS) ||
                     ( cfg_is_dest && int'(cfg_port_sel) >= NUM_WRITE_PORTS))) ||
      (commit_valid && commit_ready && int'(commit_rca_sel) >= NUM_RCAS) ||
      (rd_en && int'(rd_rca_sel) >= NUM_RCAS);

  // Sticky error flag; a new error outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_cfg_err <= 1'b0;
    else if (w_err_set)   r_cfg_err <= 1'b1;
    else if (cfg_err_clr) r_cfg_err <= 1'b0;
  end

  assign cfg_err = r_cfg_err;
`endif

endmodule : rca_config_bank
`default_nettype wire

// File: tb/tb_rca_config_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_config_bank
// Description : Directed self-checking bench for rca_config_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_config_bank;

  logic             clk;
  logic             rst_n;
  logic             cfg_wr_valid;
  logic             cfg_wr_ready;
  logic [1:0]       cfg_rca_sel;
  logic             cfg_is_dest;
  logic [2:0]       cfg_port_sel;
  logic [4:0]       cfg_reg_addr;
  logic             commit_valid;
  logic             commit_ready;
  logic [1:0]       commit_rca_sel;
  logic [2:0]       rca_busy;
  logic             rd_en;
  logic [1:0]       rd_rca_sel;
  logic [4:0][4:0]  rd_src_addrs;
  logic [1:0][4:0]  rd_dest_addrs;
  logic             rd_cfg_valid;
  logic [2:0]       commit_pending;
`ifdef RCA_CFG_ERR_EN
  logic             cfg_err_clr;
  logic             cfg_err;
`endif

  int r_tests;
  int r_fails;

  rca_config_bank u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_wr_valid   (cfg_wr_valid),
    .cfg_wr_ready   (cfg_wr_ready),
    .cfg_rca_sel    (cfg_rca_sel),
    .cfg_is_dest    (cfg_is_dest),
    .cfg_port_sel   (cfg_port_sel),
    .cfg_reg_addr   (cfg_reg_addr),
    .commit_valid   (commit_valid),
    .commit_ready   (commit_ready),
    .commit_rca_sel (commit_rca_sel),
    .rca_busy       (rca_busy),
    .rd_en          (rd_en),
    .rd_rca_sel     (rd_rca_sel),
    .rd_src_addrs   (rd_src_addrs),
    .rd_dest_addrs  (rd_dest_addrs),
    .rd_cfg_valid   (rd_cfg_valid),
    .commit_pending (commit_pending)
`ifdef RCA_CFG_ERR_EN
    ,
    .cfg_err_clr    (cfg_err_clr),
    .cfg_err        (cfg_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    r_tests++;
    if (act !== exp) begin
      r_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] rca, input logic dst, input logic [2:0] port,
                    input logic [4:0] addr);
    cfg_wr_valid = 1'b1;
    cfg_rca_sel  = rca;
    cfg_is_dest  = dst;
    cfg_port_sel = port;
    cfg_reg_addr = addr;
    tick();
    cfg_wr_valid = 1'b0;
  endtask

  task automatic commit(input logic [1:0] rca);
    commit_valid   = 1'b1;
    commit_rca_sel = rca;
    tick();
    commit_valid   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] rca);
    rd_en      = 1'b1;
    rd_rca_sel = rca;
    tick();
    rd_en      = 1'b0;
  endtask

  initial begin
    r_tests = 0;
    r_fails = 0;
    rst_n = 1'b0;
    cfg_wr_valid = 0; cfg_rca_sel = 0; cfg_is_dest = 0; cfg_port_sel = 0;
    cfg_reg_addr = 0; commit_valid = 0; commit_rca_sel = 0; rca_busy = 0;
    rd_en = 0; rd_rca_sel = 0;
`ifdef RCA_CFG_ERR_EN
    cfg_err_clr = 0;
`endif
    #12 rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_pending", commit_pending, 3'b000);
    check("rst_rd_valid", rd_cfg_valid, 1'b0);
    rd(2'd0);
    check("rst_rd_src", rd_src_addrs, 25'h0);
    check("rst_rd_dest", rd_dest_addrs, 10'h0);
    check("rst_rd_valid2", rd_cfg_valid, 1'b0);

    // Basic write/commit/read on RCA1: src[2]=7 -> 7<<10, dest[1]=12 -> 12<<5
    wr(2'd1, 1'b0, 3'd2, 5'd7);
    wr(2'd1, 1'b1, 3'd1, 5'd12);
    commit(2'd1);
    check("c1_pending", commit_pending, 3'b010);
    tick();
    check("c1_done", commit_pending, 3'b000);
    rd(2'd1);
    check("c1_src", rd_src_addrs, 25'h1C00);
    check("c1_dest", rd_dest_addrs, 10'h180);
    check("c1_valid", rd_cfg_valid, 1'b1);

    // RCA2: establish old value src[0]=5, then stage 21 and commit while busy
    wr(2'd2, 1'b0, 3'd0, 5'd5);
    commit(2'd2);
    tick();
    wr(2'd2, 1'b0, 3'd0, 5'd21);
    rca_busy = 3'b100;
    commit(2'd2);
    for (int k = 0; k < 4; k++) begin
      cfg_rca_sel    = 2'd2;
      commit_rca_sel = 2'd2;
      #1;
      check("busy_pending", commit_pending[2], 1'b1);
      check("busy_wr_ready", cfg_wr_ready, 1'b0);
      check("busy_commit_ready", commit_ready, 1'b0);
      rd(2'd2);
      check("busy_rd_old", rd_src_addrs, 25'd5);
    end
    // Busy drops with a read in the same cycle: read sees pre-copy contents
    rca_busy   = 3'b000;
    rd_en      = 1'b1;
    rd_rca_sel = 2'd2;
    tick();
    rd_en = 1'b0;
    check("copy_rd_precopy", rd_src_addrs, 25'd5);
    check("copy_pending_clr", commit_pending, 3'b000);
    rd(2'd2);
    check("copy_rd_new", rd_src_addrs, 25'd21);
    check("copy_rd_valid", rd_cfg_valid, 1'b1);

    // Same-cycle write and commit to RCA0
    cfg_wr_valid = 1'b1; cfg_rca_sel = 2'd0; cfg_is_dest = 1'b0;
    cfg_port_sel = 3'd0; cfg_reg_addr = 5'd3;
    commit_valid = 1'b1; commit_rca_sel = 2'd0;
    #1;
    check("same_wr_ready", cfg_wr_ready, 1'b1);
    check("same_commit_ready", commit_ready, 1'b1);
    tick();
    cfg_wr_valid = 1'b0; commit_valid = 1'b0;
    check("same_pending", commit_pending, 3'b001);
    tick();
    rd(2'd0);
    check("same_rd_src", rd_src_addrs, 25'd3);
    check("same_rd_valid", rd_cfg_valid, 1'b1);

    // Out-of-range port writes are accepted and dropped
    cfg_rca_sel = 2'd1; cfg_is_dest = 1'b0; cfg_port_sel = 3'd6;
    #1;
    check("oor_wr_ready", cfg_wr_ready, 1'b1);
    wr(2'd1, 1'b0, 3'd6, 5'd31);
`ifdef RCA_CFG_ERR_EN
    check("err_set_wr", cfg_err, 1'b1);
    tick();
    check("err_sticky", cfg_err, 1'b1);
    cfg_err_clr = 1'b1;
    tick();
    cfg_err_clr = 1'b0;
    check("err_clr", cfg_err, 1'b0);
`endif
    wr(2'd1, 1'b1, 3'd2, 5'd31);
    commit(2'd1);
    tick();
    rd(2'd1);
    check("oor_src_same", rd_src_addrs, 25'h1C00);
    check("oor_dest_same", rd_dest_addrs, 10'h180);

    // Out-of-range RCA: commit ready and dropped, read returns zeros
    commit_rca_sel = 2'd3;
    #1;
    check("oor_commit_ready", commit_ready, 1'b1);
    commit(2'd3);
    check("oor_commit_nopend", commit_pending, 3'b000);
    rd(2'd3);
    check("oor_rd_src", rd_src_addrs, 25'h0);
    check("oor_rd_valid", rd_cfg_valid, 1'b0);
`ifdef RCA_CFG_ERR_EN
    check("err_set_rd", cfg_err, 1'b1);
`endif

    // Asynchronous reset while RCA0 is pending
    wr(2'd0, 1'b0, 3'd1, 5'd9);
    rca_busy = 3'b001;
    commit(2'd0);
    check("ar_pending", commit_pending, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    check("ar_pending_clr", commit_pending, 3'b000);
    check("ar_rd_valid_clr", rd_cfg_valid, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    rca_busy = 3'b000;
    tick();
    check("ar_still_idle", commit_pending, 3'b000);
    rd(2'd0);
    check("ar_rd_src", rd_src_addrs, 25'h0);
    check("ar_rd_valid", rd_cfg_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
    $finish;
  end

endmodule : tb_rca_config_bank
`default_nettype wire
